// File: rtl/shift_rotate_arbiter.sv
// ----------------------------------------------------------------------------
// shift_rotate_arbiter
//   Shares one combinational shift_rotate_unit between two requesters.
//   Round-robin arbitration, operand registering, one EXEC cycle driving the
//   unit, result capture, and routing of the result back to the owner.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op          request channel of requester N (N=0,1)
//   respN_valid/ready/data           response channel of requester N
//   sru_a/sru_b/sru_op               operands presented to the unit
//   sru_out                          result returned by the unit
// ----------------------------------------------------------------------------
module shift_rotate_arbiter #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [AMT_W-1:0]  req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [AMT_W-1:0]  req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [DATA_W-1:0] sru_a,
  output logic [AMT_W-1:0]  sru_b,
  output logic [OP_W-1:0]   sru_op,
  input  logic [DATA_W-1:0] sru_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [DATA_W-1:0]   a_q;
  logic [AMT_W-1:0]    b_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   res_q;

  logic gnt0, gnt1;

  // On a tie, the requester that did not win last time is granted.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant_q);
    gnt1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready  = (state_q == IDLE) && gnt0;
  assign req1_ready  = (state_q == IDLE) && gnt1;
  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) &&  owner_q;
  // Both response data outputs carry the captured result; only the owner's
  // valid qualifies it.
  assign resp0_data  = res_q;
  assign resp1_data  = res_q;
  assign sru_a       = a_q;
  assign sru_b       = b_q;
  assign sru_op      = op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0) begin
            a_q     <= req0_a;
            b_q     <= req0_b;
            op_q    <= req0_op;
            owner_q <= 1'b0;
            state_q <= EXEC;
          end else if (gnt1) begin
            a_q     <= req1_a;
            b_q     <= req1_b;
            op_q    <= req1_op;
            owner_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= sru_out;
          state_q <= RESP;
        end
        RESP: begin
          if (owner_q ? resp1_ready : resp0_ready) begin
            last_grant_q <= owner_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_arbiter.sv
module tb_shift_rotate_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [DW-1:0] req0_a, resp0_data;
  logic [AW-1:0] req0_b;
  logic [OW-1:0] req0_op;
  logic          req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [DW-1:0] req1_a, resp1_data;
  logic [AW-1:0] req1_b;
  logic [OW-1:0] req1_op;
  logic [DW-1:0] sru_a, sru_out;
  logic [AW-1:0] sru_b;
  logic [OW-1:0] sru_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural model of the shared unit: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR.
  function automatic logic [DW-1:0] unit_f(input logic [DW-1:0] a,
                                           input logic [AW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      3'd0: unit_f = a << b;
      3'd1: unit_f = a >> b;
      3'd2: unit_f = $unsigned($signed(a) >>> b);
      3'd3: unit_f = (a << b) | (a >> (DW - int'(b)));
      3'd4: unit_f = (a >> b) | (a << (DW - int'(b)));
      default: unit_f = a;
    endcase
  endfunction

  assign sru_out = unit_f(sru_a, sru_b, sru_op);

  shift_rotate_arbiter #(.DATA_W(DW), .AMT_W(AW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .sru_a(sru_a), .sru_b(sru_b), .sru_op(sru_op), .sru_out(sru_out)
  );

  task automatic idle_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; resp0_ready = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; resp1_ready = 0;
  endtask

  // Ends at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset(); #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b required 0000",
                         {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    checks++;
    if (sru_a !== '0 || sru_b !== '0 || sru_op !== '0 || resp0_data !== '0) begin
      errors++; $display("FAIL reset_regs got a=%h b=%h op=%h res=%h required zeros",
                         sru_a, sru_b, sru_op, resp0_data);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp;
    exp = 32'hCE4E4E48;
    req0_valid = 1; req0_a = 32'hF9C9C9C9; req0_b = 3; req0_op = 3'b000;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant got r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); @(negedge clk); req0_valid = 0; #1;
    checks++;
    if (req0_ready !== 1'b0 || sru_a !== 32'hF9C9C9C9 || sru_b !== 5'd3 || resp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_exec got r0=%b a=%h b=%0d v0=%b required 0 f9c9c9c9 3 0",
                         req0_ready, sru_a, sru_b, resp0_valid);
    end
    next_cycle();
    checks++;
    if (resp0_valid !== 1'b1 || resp0_data !== exp || resp1_valid !== 1'b0) begin
      errors++; $display("FAIL single_resp got v0=%b d=%h v1=%b required 1 %h 0",
                         resp0_valid, resp0_data, resp1_valid, exp);
    end
    resp0_ready = 1;
    next_cycle();
    checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got v0=%b v1=%b required 0 0", resp0_valid, resp1_valid);
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [DW-1:0] exp;
    int wait_n;
    int got;
    idle_inputs();
    do_reset();
    req0_valid = 1; req0_a = 32'hF0000000; req0_b = 4; req0_op = 3'b001;
    req1_valid = 1; req1_a = 32'd20;       req1_b = 3; req1_op = 3'b000;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      wait_n = 0;
      while (!(req0_ready || req1_ready) && wait_n < 10) begin
        next_cycle(); wait_n++;
      end
      checks++;
      if (wait_n >= 10) begin
        errors++; $display("FAIL fair_timeout op %0d got no grant required grant", k);
        break;
      end
      got = req1_ready ? 1 : 0;
      checks++;
      if (got != (k % 2) || (req0_ready && req1_ready)) begin
        errors++; $display("FAIL fair_order op %0d got r0=%b r1=%b required port %0d",
                           k, req0_ready, req1_ready, k % 2);
      end
      exp = (k % 2) ? 32'h000000A0 : 32'h0F000000;
      next_cycle();
      next_cycle();
      checks++;
      if ((k % 2) ? (resp1_valid !== 1'b1 || resp1_data !== exp || resp0_valid !== 1'b0)
                  : (resp0_valid !== 1'b1 || resp0_data !== exp || resp1_valid !== 1'b0)) begin
        errors++; $display("FAIL fair_resp op %0d got v0=%b v1=%b d0=%h d1=%h required port %0d data %h",
                           k, resp0_valid, resp1_valid, resp0_data, resp1_data, k % 2, exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp;
    idle_inputs();
    do_reset();
    req1_valid = 1; req1_a = 32'h12345678; req1_b = 8; req1_op = 3'b011;
    exp = 32'h34567812;
    #1;
    next_cycle();            // EXEC
    req1_valid = 0;
    req0_valid = 1; req0_a = 32'h00000001; req0_b = 1; req0_op = 3'b000;
    next_cycle();            // RESP
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp1_valid !== 1'b1 || resp1_data !== exp || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0 || resp0_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v1=%b d1=%h r0=%b r1=%b v0=%b required 1 %h 0 0 0",
                           i, resp1_valid, resp1_data, req0_ready, req1_ready, resp0_valid, exp);
      end
      next_cycle();
    end
    resp1_ready = 1;
    next_cycle();
    checks++;
    if (resp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v1=%b r0=%b required 0 1", resp1_valid, req0_ready);
    end
    resp1_ready = 0; resp0_ready = 1;
    next_cycle(); req0_valid = 0;
    next_cycle();
    checks++;
    if (resp0_valid !== 1'b1 || resp0_data !== 32'h2) begin
      errors++; $display("FAIL bp_next got v0=%b d0=%h required 1 00000002", resp0_valid, resp0_data);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    do_reset();
    // reset during EXEC
    req0_valid = 1; req0_a = 32'hAAAA5555; req0_b = 2; req0_op = 3'b001; resp0_ready = 1;
    @(posedge clk); @(negedge clk);
    req0_valid = 0; rst = 1;
    @(posedge clk); @(negedge clk); rst = 0; #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0 || sru_a !== '0) begin
      errors++; $display("FAIL rst_exec got flags=%b sru_a=%h required 0000 0",
                         {req0_ready, req1_ready, resp0_valid, resp1_valid}, sru_a);
    end
    next_cycle(); next_cycle();
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++; $display("FAIL rst_exec_lost got v0=%b required 0", resp0_valid);
    end
    // reset during RESP
    req1_valid = 1; req1_a = 32'h0000FFFF; req1_b = 4; req1_op = 3'b000; resp1_ready = 0;
    next_cycle(); req1_valid = 0;
    next_cycle();
    checks++;
    if (resp1_valid !== 1'b1) begin
      errors++; $display("FAIL rst_resp_setup got v1=%b required 1", resp1_valid);
    end
    rst = 1;
    @(posedge clk); @(negedge clk); rst = 0; #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
      errors++; $display("FAIL rst_resp got flags=%b required 0000",
                         {req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
    // tie after reset goes to requester 0
    req0_valid = 1; req0_a = 32'h00000003; req0_b = 5; req0_op = 3'b000;
    req1_valid = 1; req1_a = 32'h00000007; req1_b = 1; req1_op = 3'b000;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_tie got r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    next_cycle(); req0_valid = 0; req1_valid = 0;
    next_cycle();
    checks++;
    if (resp0_valid !== 1'b1 || resp0_data !== 32'h60 || resp1_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after got v0=%b d0=%h v1=%b required 1 00000060 0",
                         resp0_valid, resp0_data, resp1_valid);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_amount();
    logic [DW-1:0] ta [3];
    logic [AW-1:0] tb [3];
    logic [OW-1:0] to [3];
    logic [DW-1:0] exp;
    ta[0] = 32'h80000001; tb[0] = 5'd0;     to[0] = 3'b011;
    ta[1] = 32'h80000001; tb[1] = 5'd31;    to[1] = 3'b011;
    ta[2] = 32'h12345678; tb[2] = 5'b11100; to[2] = 3'b100;
    idle_inputs();
    resp0_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp = unit_f(ta[i], tb[i], to[i]);
      req0_valid = 1; req0_a = ta[i]; req0_b = tb[i]; req0_op = to[i];
      #1;
      next_cycle(); req0_valid = 0;
      checks++;
      if (sru_b !== tb[i] || sru_a !== ta[i] || sru_op !== to[i]) begin
        errors++; $display("FAIL amt_pass %0d got b=%0d a=%h op=%0d required %0d %h %0d",
                           i, sru_b, sru_a, sru_op, tb[i], ta[i], to[i]);
      end
      next_cycle();
      checks++;
      if (resp0_valid !== 1'b1 || resp0_data !== exp) begin
        errors++; $display("FAIL amt_resp %0d got v0=%b d0=%h required 1 %h", i, resp0_valid, resp0_data, exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_idle_hold();
    idle_inputs();
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0 ||
          sru_a !== 32'h12345678 || sru_b !== 5'd28 || sru_op !== 3'b100) begin
        errors++; $display("FAIL idle_hold cyc %0d got flags=%b a=%h b=%0d op=%0d required 0000 12345678 28 4",
                           i, {req0_ready, req1_ready, resp0_valid, resp1_valid}, sru_a, sru_b, sru_op);
      end
      next_cycle();
    end
  endtask

  // Transaction-level model: at most one operation outstanding; phase 0 is
  // the execute cycle, later cycles are the response until the owner takes it.
  task automatic test_random();
    bit busy = 0;
    int phase = 0;
    bit own = 0;
    bit prev = 1;
    bit e0, e1;
    logic [DW-1:0] xa, xd;
    logic [AW-1:0] xb;
    logic [OW-1:0] xo;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = AW'($urandom); req0_op = OW'($urandom_range(0, 5));
      req1_a = $urandom; req1_b = AW'($urandom); req1_op = OW'($urandom_range(0, 5));
      resp0_ready = ($urandom_range(0, 2) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      e0 = 0; e1 = 0;
      checks++;
      if (!busy) begin
        e0 = req0_valid && (!req1_valid || prev);
        e1 = req1_valid && (!req0_valid || !prev);
        if (req0_ready !== e0 || req1_ready !== e1 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_idle cyc %0d got r=%b%b v=%b%b required r=%b%b v=00",
                             c, req0_ready, req1_ready, resp0_valid, resp1_valid, e0, e1);
        end
      end else if (phase == 0) begin
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== 1'b0 ||
            resp1_valid !== 1'b0 || sru_a !== xa || sru_b !== xb || sru_op !== xo) begin
          errors++; $display("FAIL rnd_exec cyc %0d got r=%b%b v=%b%b a=%h b=%0d op=%0d required 00 00 %h %0d %0d",
                             c, req0_ready, req1_ready, resp0_valid, resp1_valid, sru_a, sru_b, sru_op, xa, xb, xo);
        end
      end else begin
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== !own ||
            resp1_valid !== own || (own ? resp1_data : resp0_data) !== xd) begin
          errors++; $display("FAIL rnd_resp cyc %0d got r=%b%b v=%b%b d=%h required 00 owner %0d data %h",
                             c, req0_ready, req1_ready, resp0_valid, resp1_valid,
                             own ? resp1_data : resp0_data, own, xd);
        end
      end
      @(posedge clk);
      if (!busy) begin
        if (e0 || e1) begin
          busy = 1; phase = 0; own = e1;
          xa = own ? req1_a : req0_a;
          xb = own ? req1_b : req0_b;
          xo = own ? req1_op : req0_op;
          xd = unit_f(xa, xb, xo);
        end
      end else if (phase == 0) begin
        phase = 1;
      end else if (own ? resp1_ready : resp0_ready) begin
        busy = 0; prev = own;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_amount();
    test_idle_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end
endmodule
